// File: rtl/seg_addsub_seq.sv
// Segment-serial wide adder/subtractor: one SEG_WIDTH slice per clock through a prefix adder.
// Define SEG_ADDSUB_ZERO_FLAG_EN to add the out_zero result flag.
module seg_addsub_seq #(
  parameter int unsigned OP_WIDTH  = 1024,
  parameter int unsigned SEG_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_a,
  input  logic [OP_WIDTH-1:0] in_b,
  input  logic                in_sub,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_sum,
`ifdef SEG_ADDSUB_ZERO_FLAG_EN
  output logic                out_zero,
`endif
  output logic                out_cout
);

  localparam int unsigned NSEG      = OP_WIDTH / SEG_WIDTH;
  localparam int unsigned SEG_CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned LEVELS    = $clog2(SEG_WIDTH);
  localparam int unsigned IDX_W     = $clog2(OP_WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [OP_WIDTH-1:0]  a_q, b_q, sum_q;
  logic                 sub_q, carry_q, cout_q;
  logic [SEG_CNT_W-1:0] seg_cnt_q;
  logic                 zero_q;

  logic                 accept;
  logic                 last_seg;
  logic [IDX_W-1:0]     seg_base;
  logic [SEG_WIDTH-1:0] a_seg, b_seg;
  logic [SEG_WIDTH-1:0] seg_sum;
  logic                 seg_cout;
  logic [SEG_WIDTH-1:0] carry_vec;
  logic [SEG_WIDTH-1:0] g_lvl [LEVELS+1];
  logic [SEG_WIDTH-1:0] p_lvl [LEVELS+1];

  // SEG_WIDTH is a power of two, so the segment base is a plain shift of the counter.
  assign seg_base = IDX_W'({seg_cnt_q, {LEVELS{1'b0}}});
  assign a_seg    = a_q[seg_base +: SEG_WIDTH];
  assign b_seg    = b_q[seg_base +: SEG_WIDTH];
  assign last_seg = (seg_cnt_q == SEG_CNT_W'(NSEG - 1));
  assign accept   = in_valid && in_ready;

  // Kogge-Stone prefix tree of (generate, propagate) pairs.
  always_comb begin
    g_lvl[0] = a_seg & b_seg;
    p_lvl[0] = a_seg ^ b_seg;
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int i = 0; i < SEG_WIDTH; i++) begin
        if (i >= (1 << lv)) begin
          g_lvl[lv+1][i] = g_lvl[lv][i] | (p_lvl[lv][i] & g_lvl[lv][i-(1<<lv)]);
          p_lvl[lv+1][i] = p_lvl[lv][i] & p_lvl[lv][i-(1<<lv)];
        end else begin
          g_lvl[lv+1][i] = g_lvl[lv][i];
          p_lvl[lv+1][i] = p_lvl[lv][i];
        end
      end
    end
  end

  // Fold the registered inter-segment carry into each prefix group.
  always_comb begin
    carry_vec    = '0;
    carry_vec[0] = carry_q;
    for (int i = 1; i < SEG_WIDTH; i++) begin
      carry_vec[i] = g_lvl[LEVELS][i-1] | (p_lvl[LEVELS][i-1] & carry_q);
    end
    seg_sum  = p_lvl[0] ^ carry_vec;
    seg_cout = g_lvl[LEVELS][SEG_WIDTH-1] | (p_lvl[LEVELS][SEG_WIDTH-1] & carry_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_seg) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      seg_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else if (accept) begin
      a_q       <= in_a;
      // Subtract runs as A + ~B + ~cin so the same adder serves both operations.
      b_q       <= in_sub ? ~in_b : in_b;
      sub_q     <= in_sub;
      carry_q   <= in_sub ^ in_cin;
      seg_cnt_q <= '0;
      zero_q    <= 1'b1;
    end else if (state_q == StRun) begin
      sum_q[seg_base +: SEG_WIDTH] <= seg_sum;
      carry_q                      <= seg_cout;
      zero_q                       <= zero_q & (seg_sum == '0);
      if (last_seg) begin
        cout_q <= sub_q ^ seg_cout;
      end else begin
        seg_cnt_q <= seg_cnt_q + 1'b1;
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
`ifdef SEG_ADDSUB_ZERO_FLAG_EN
  assign out_zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule
